sram_like_arbiter: RTL

SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

---
 rtl/sram_like_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sram_like_arbiter.sv
// Two-master SRAM-like arbiter: instruction and data masters share one slave
// port, with one transaction outstanding and starvation protection for inst.
module sram_like_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic [3:0] starve_q, starve_d;

    logic sel_data;
    logic sel_any;
    logic cur_data;
    logic req_on;
    logic grant;
    logic done;

    // owner_q: 1 = data master, 0 = instruction master
    always_comb begin
        sel_data = data_req && !((starve_q == SMAX) && inst_req);
        sel_any  = inst_req || data_req;
        cur_data = owner_q;
        req_on   = 1'b0;
        grant    = 1'b0;
        done     = 1'b0;
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;

        unique case (state_q)
            IDLE: begin
                cur_data = sel_data;
                req_on   = sel_any;
                grant    = sel_any && s_addr_ok;
                if (sel_any) begin
                    owner_d = sel_data;
                    state_d = s_addr_ok ? DATA : ADDR;
                end
            end
            ADDR: begin
                req_on = owner_q ? data_req : inst_req;
                grant  = s_addr_ok;
                if (s_addr_ok) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                done = s_data_ok;
                if (s_data_ok) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (grant) begin
            if (cur_data && inst_req) begin
                starve_d = (starve_q >= SMAX) ? SMAX : starve_q + 4'd1;
            end else begin
                starve_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    // Reset gates the handshake outputs directly so they drop without a clock
    assign s_req   = !rst && req_on;
    assign s_wr    = cur_data ? data_wr    : inst_wr;
    assign s_size  = cur_data ? data_size  : inst_size;
    assign s_addr  = cur_data ? data_addr  : inst_addr;
    assign s_wdata = cur_data ? data_wdata : inst_wdata;

    assign inst_addr_ok = !rst && grant && !cur_data;
    assign data_addr_ok = !rst && grant && cur_data;
    assign inst_data_ok = !rst && done && !cur_data;
    assign data_data_ok = !rst && done && cur_data;

    assign inst_rdata = s_rdata;
    assign data_rdata = s_rdata;

endmodule
